// File: rtl/swing_digest_collector.sv
// swing_digest_collector
// Buffers (A, B, AND) word triplets from the upstream word stage in a small
// FIFO and folds them, BLOCK_LEN at a time, into a rotate-XOR digest that is
// offered on a valid/ready output port.
// Optional statistics outputs (blocks_done, fifo_stall) are built when the
// macro SWING_DIGEST_STATS_EN is defined.
module swing_digest_collector #(
    parameter int               WIDTH      = 4,
    parameter int               BLOCK_LEN  = 8,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] IV         = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] and_in,
    output logic [WIDTH-1:0] digest,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic             busy
`ifdef SWING_DIGEST_STATS_EN
    ,
    output logic [7:0]       blocks_done,
    output logic [0:0]       fifo_stall
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WC_W  = $clog2(BLOCK_LEN + 1);

    typedef enum logic {ACCUM, EMIT} state_t;

    // Word function: three-way sum, carries beyond WIDTH discarded.
    function automatic logic [WIDTH-1:0] word_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] c);
        return a + b + c;
    endfunction

    // Fold step: rotate the accumulator left by one, then XOR in the word.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] acc_cur,
                                              input logic [WIDTH-1:0] w);
        return {acc_cur[WIDTH-2:0], acc_cur[WIDTH-1]} ^ w;
    endfunction

    logic [WIDTH-1:0] mem_a   [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_b   [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_and [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [WC_W-1:0]  word_cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    state_t           state;
    logic             push;
    logic             pop;

    assign push     = in_valid && in_ready;
    assign pop      = (state == ACCUM) && (count != '0);
    assign acc_next = fold(acc, word_sum(mem_a[rd_ptr], mem_b[rd_ptr], mem_and[rd_ptr]));
    assign busy     = (state == EMIT) || (word_cnt != '0);

    // Occupancy after this cycle's push/pop; feeds the registered ready flag.
    always_comb begin
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= a_in;
            mem_b[wr_ptr]   <= b_in;
            mem_and[wr_ptr] <= and_in;
        end
    end

    // FIFO pointers, occupancy and registered ready (depends only on occupancy).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_next;
            in_ready <= (count_next != CNT_W'(FIFO_DEPTH));
        end
    end

    // Fold/emit FSM: accumulate BLOCK_LEN words, then hold the digest until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACCUM;
            acc          <= IV;
            word_cnt     <= '0;
            digest       <= IV;
            digest_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (pop) begin
                        if (word_cnt == WC_W'(BLOCK_LEN - 1)) begin
                            digest       <= acc_next;
                            digest_valid <= 1'b1;
                            acc          <= IV;
                            word_cnt     <= '0;
                            state        <= EMIT;
                        end else begin
                            acc      <= acc_next;
                            word_cnt <= word_cnt + WC_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (digest_valid && digest_ready) begin
                        digest_valid <= 1'b0;
                        state        <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef SWING_DIGEST_STATS_EN
    // Statistics: saturating handshake count and one-cycle-late stall flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            blocks_done <= 8'd0;
            fifo_stall  <= 1'b0;
        end else begin
            if (digest_valid && digest_ready && blocks_done != 8'hFF)
                blocks_done <= blocks_done + 8'd1;
            fifo_stall <= in_valid && !in_ready;
        end
    end
`endif

endmodule
